// File: rtl/header_stream_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : avalon_st_if
//  Description : Avalon-ST beat bundle (valid/ready/sop/eop/data/empty).
//                The master drives the beat and the slave returns ready.
//  Revision    : 1.0  initial release
// ============================================================================
interface avalon_st_if #(
    parameter int DATA_WIDTH  = 128,
    parameter int EMPTY_WIDTH = $clog2(DATA_WIDTH/8)
);
    logic                   valid;
    logic                   ready;
    logic                   sop;
    logic                   eop;
    logic [DATA_WIDTH-1:0]  data;
    logic [EMPTY_WIDTH-1:0] empty;

    modport master (output valid, sop, eop, data, empty, input ready);
    modport slave  (input valid, sop, eop, data, empty, output ready);
endinterface
`default_nettype wire

// File: rtl/header_stream_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : header_stream_arbiter
//  Description : Packet-granular round-robin arbiter that shares a single
//                header_adder among NUM_SRC Avalon-ST sources. A source is
//                locked from arbitration until its eop beat is accepted, so
//                packets never interleave. The granted source's header is
//                captured at arbitration and held for the whole packet.
//  Options     : ARB_PKT_STATS_EN - per-source completed-packet counters
//                (pkt_cnt, cleared by cnt_clr). Undefined: pkt_cnt is 0.
//  Revision    : 1.0  initial release
// ============================================================================
module header_stream_arbiter #(
    parameter int NUM_SRC     = 4,
    parameter int DATA_WIDTH  = 128,
    parameter int EMPTY_WIDTH = $clog2(DATA_WIDTH/8),
    parameter int HEADER_SIZE = 256,
    localparam int ID_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  wire                           clk,
    input  wire                           rst_n,
    input  wire [NUM_SRC-1:0]             in_valid,
    output logic [NUM_SRC-1:0]            in_ready,
    input  wire [NUM_SRC-1:0]             in_sop,
    input  wire [NUM_SRC-1:0]             in_eop,
    input  wire [NUM_SRC*DATA_WIDTH-1:0]  in_data,
    input  wire [NUM_SRC*EMPTY_WIDTH-1:0] in_empty,
    input  wire [NUM_SRC*HEADER_SIZE-1:0] header_tbl,
    avalon_st_if.master                   data_out,
    output logic [HEADER_SIZE-1:0]        header_data,
    output logic                          grant_valid,
    output logic [ID_W-1:0]               grant_id,
    input  wire                           cnt_clr,
    output wire [NUM_SRC*32-1:0]          pkt_cnt
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [ID_W-1:0]          r_last_grant;
    logic [ID_W-1:0]          r_grant_id;
    logic [HEADER_SIZE-1:0]   r_header_data;
    logic [ID_W-1:0]          w_pick;
    logic [ID_W-1:0]          w_idx;
    logic                     w_found;
    logic                     w_eop_accept;

    logic [DATA_WIDTH-1:0]    w_data_arr  [NUM_SRC];
    logic [EMPTY_WIDTH-1:0]   w_empty_arr [NUM_SRC];
    logic [HEADER_SIZE-1:0]   w_hdr_arr   [NUM_SRC];

    // Unpack the flat per-source buses so the granted lane can be indexed directly
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
        assign w_data_arr[gi]  = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
        assign w_empty_arr[gi] = in_empty[gi*EMPTY_WIDTH +: EMPTY_WIDTH];
        assign w_hdr_arr[gi]   = header_tbl[gi*HEADER_SIZE +: HEADER_SIZE];
    end

    // Round-robin search: first valid source after the last granted one, wrapping
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            w_idx = ID_W'((int'(r_last_grant) + k) % NUM_SRC);
            if (!w_found && in_valid[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    // The packet ends when the granted source's eop beat is accepted downstream
    assign w_eop_accept = (r_state == S_LOCK) && in_valid[r_grant_id]
                          && data_out.ready && in_eop[r_grant_id];

    // Next state and pass-through outputs; only the locked source sees ready
    always_comb begin
        w_state_nxt    = r_state;
        in_ready       = '0;
        grant_valid    = 1'b0;
        data_out.valid = 1'b0;
        data_out.sop   = 1'b0;
        data_out.eop   = 1'b0;
        data_out.data  = w_data_arr[r_grant_id];
        data_out.empty = w_empty_arr[r_grant_id];
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_LOCK;
                end
            end
            S_LOCK: begin
                grant_valid          = 1'b1;
                data_out.valid       = in_valid[r_grant_id];
                data_out.sop         = in_sop[r_grant_id];
                data_out.eop         = in_eop[r_grant_id];
                in_ready[r_grant_id] = data_out.ready;
                if (w_eop_accept) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant bookkeeping: capture id/header at arbitration, remember owner at eop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_id    <= '0;
            r_header_data <= '0;
            r_last_grant  <= ID_W'(NUM_SRC - 1);
        end else begin
            if (r_state == S_IDLE && w_found) begin
                r_grant_id    <= w_pick;
                r_header_data <= w_hdr_arr[w_pick];
            end
            if (w_eop_accept) begin
                r_last_grant <= r_grant_id;
            end
        end
    end

    assign grant_id    = r_grant_id;
    assign header_data = r_header_data;

`ifdef ARB_PKT_STATS_EN
    for (genvar gc = 0; gc < NUM_SRC; gc++) begin : g_pkt_cnt
        logic [31:0] r_cnt;

        // Completed-packet counter; clear wins over a same-cycle increment
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (cnt_clr) begin
                r_cnt <= '0;
            end else if (w_eop_accept && (r_grant_id == ID_W'(gc))) begin
                r_cnt <= r_cnt + 32'd1;
            end
        end

        assign pkt_cnt[gc*32 +: 32] = r_cnt;
    end
`else
    assign pkt_cnt = '0;
    wire w_unused_cnt_clr = cnt_clr;
`endif

endmodule
`default_nettype wire
